// File: rtl/fb_loader.sv
`default_nettype none
// ============================================================================
// Module      : fb_loader
// Description : Write-side agent for the grey-level frame buffer. Converts a
//               raster-order pixel stream (x fastest) into column-major
//               frame buffer writes (address = x*IMG_H + y), and can fill the
//               whole buffer with a constant on a clear command.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_loader #(
  parameter int IMG_W  = 80,
  parameter int IMG_H  = 80,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] clear_value,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [DATA_W-1:0] clear_val_q, clear_val_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;

  logic              is_busy;
  logic              cmd;
  logic              last_pix;
  logic [ADDR_W-1:0] pix_addr;

  assign is_busy  = (state_q == S_LOAD) || (state_q == S_CLEAR);
  assign cmd      = start || clear;
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
  // Column-major mapping: each column of IMG_H pixels is contiguous.
  assign pix_addr = ADDR_W'(x_q) * ADDR_W'(IMG_H) + ADDR_W'(y_q);

  // A command arriving while busy aborts the frame, so the beat on that
  // cycle is refused rather than written into the restarted frame.
  assign in_ready   = (state_q == S_LOAD) && !cmd;
  assign busy       = is_busy;
  assign we         = we_q;
  assign address    = address_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;

  // Next-state, raster position and one-cycle-delayed write port.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    clear_val_d  = clear_val_q;
    we_d         = 1'b0;
    address_d    = address_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;

    if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (clear) begin
      state_d     = S_CLEAR;
      clear_val_d = clear_value;
      x_d         = '0;
      y_d         = '0;
    end else if (start) begin
      state_d = S_LOAD;
      x_d     = '0;
      y_d     = '0;
    end else if ((state_q == S_LOAD && in_valid) || state_q == S_CLEAR) begin
      we_d      = 1'b1;
      address_d = pix_addr;
      wr_data_d = (state_q == S_LOAD) ? in_data : clear_val_q;
      if (last_pix) begin
        state_d      = S_DONE;
        frame_done_d = 1'b1;
        x_d          = '0;
        y_d          = '0;
      end else if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // State and output registers; reset is immediate, even mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      clear_val_q  <= '0;
      we_q         <= 1'b0;
      address_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      clear_val_q  <= clear_val_d;
      we_q         <= we_d;
      address_q    <= address_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_loader
// Description : Self-checking bench for fb_loader with an expected-write
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_loader;

  localparam int W  = 80;
  localparam int H  = 80;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] clear_value = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] address;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          frame_done;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          done;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  fb_loader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clear       (clear),
    .clear_value (clear_value),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .we          (we),
    .address     (address),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raster byte k lands at column-major address (k%W)*H + k/W.
  function automatic logic [AW-1:0] exp_addr(input int k);
    return AW'((k % W) * H + k / W);
  endfunction

  task automatic push(input int k, input logic [DW-1:0] d);
    exp_t e;
    e.a    = exp_addr(k);
    e.d    = d;
    e.done = (k == N - 1);
    q.push_back(e);
  endtask

  // Write monitor: every we pulse must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (frame_done === 1'b1) done_cnt++;
    if (we === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_we", {31'd0, we}, 32'd0);
      end else begin
        e = q.pop_front();
        check("wr_address", {19'd0, address}, {19'd0, e.a});
        check("wr_data", {24'd0, wr_data}, {24'd0, e.d});
        check("wr_frame_done", {31'd0, frame_done}, {31'd0, e.done});
      end
    end else begin
      check("done_without_we", {31'd0, frame_done}, 32'd0);
    end
  end

  // All stimulus tasks begin and end 1 time unit after a rising edge.
  task automatic beat(input int k, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    push(k, d);
    @(negedge clk);
    check("in_ready_load", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_data  = 8'hFF;
    @(negedge clk);
    check("in_ready_idle_beat", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({tag, "_drain"}, q.size(), 32'd0);
    q.delete();
    @(negedge clk);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_count"}, done_cnt, 32'd1);
    done_cnt = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_address", {19'd0, address}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full frame, in_valid held high
    pulse_start();
    for (int k = 0; k < N; k++) beat(k, 8'(k * 7 + 1));
    drain("full", 20);

    // Full frame with in_valid toggling
    pulse_start();
    for (int k = 0; k < N; k++) begin
      beat(k, 8'($urandom_range(0, 255)));
      if (k < N - 1) idle_cycle();
    end
    drain("toggle", 20);

    // Clear fill; clear_value changes afterwards and must not matter
    clear_value = 8'h03;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    clear_value = 8'hAA;
    for (int k = 0; k < N; k++) push(k, 8'h03);
    for (int i = 0; i < N + 2; i++) begin
      in_valid = i[0];
      in_data  = 8'h77;
      @(negedge clk);
      check("clear_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("clear", 20);

    // Abort after 100 beats; the beat on the restart cycle is refused
    pulse_start();
    for (int k = 0; k < 100; k++) beat(k, 8'(k + 8'h40));
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) beat(k, 8'(k ^ 8'h5C));
    drain("abort", 20);

    // start and clear together: clear wins
    clear_value = 8'h5A;
    clear = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) push(k, 8'h5A);
    @(negedge clk);
    check("both_in_ready", {31'd0, in_ready}, 32'd0);
    check("both_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    drain("both", N + 20);
    in_valid = 1'b0;

    // Asynchronous reset mid-LOAD
    pulse_start();
    for (int k = 0; k < 50; k++) beat(k, 8'(k + 1));
    #1;
    rst = 1'b1;
    #1;
    check("arst_we", {31'd0, we}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_address", {19'd0, address}, 32'd0);
    check("arst_wr_data", {24'd0, wr_data}, 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("arst_no_done", done_cnt, 32'd0);
    @(posedge clk); #1;
    pulse_start();
    for (int k = 0; k < N; k++) beat(k, 8'(k * 3 + 9));
    drain("after_rst", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_loader.md
Name: fb_loader

Overview:
- Write-side agent for the 80x80 grey-level frame buffer that the VGA display path reads.
- Accepts a raster-order pixel byte stream over a valid/ready handshake and issues one memory write per accepted pixel.
- Translates raster order (x fastest) into the column-major address layout the display path uses: address = x*IMG_H + y.
- Also supports a clear command that fills the whole buffer with a constant. Sits between the pixel source (UART/pattern generator) and the frame buffer write port.

Parameters:
- IMG_W, 80, image width in pixels (x range 0..IMG_W-1)
- IMG_H, 80, image height in pixels (y range 0..IMG_H-1)
- ADDR_W, 13, frame buffer address width; must satisfy IMG_W*IMG_H <= 2^ADDR_W
- DATA_W, 8, pixel byte width

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: begin loading a frame at (0,0)
- clear  input  1  one-cycle pulse: fill buffer with clear_value
- clear_value  input  DATA_W  fill byte, sampled on the clear pulse
- in_data  input  DATA_W  pixel byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a beat this cycle
- we  output  1  frame buffer write enable
- address  output  ADDR_W  frame buffer write address
- wr_data  output  DATA_W  frame buffer write data
- busy  output  1  high in LOAD or CLEAR
- frame_done  output  1  one-cycle pulse when the last pixel/fill write is issued

Behaviour:
- Reset (async, rst=1): state=IDLE, x=0, y=0, in_ready=0, we=0, address=0, wr_data=0, busy=0, frame_done=0. Takes effect immediately, including mid-frame; partially written data in memory is left as is.
- States: IDLE, LOAD, CLEAR, DONE.
- IDLE:
  - clear -> CLEAR, latch clear_value.
  - else start -> LOAD.
  - x,y cleared to 0 on either transition.
- LOAD:
  - in_ready=1 (combinational from state only, not from in_valid).
  - A beat is accepted when in_valid & in_ready.
  - Next cycle: we=1, wr_data=in_data, address=x*IMG_H+y for the accepted beat's (x,y). Write latency is 1 cycle.
  - x increments per beat. At x=IMG_W-1, x wraps to 0 and y increments.
  - Beat at (IMG_W-1, IMG_H-1) -> DONE.
  - Idle cycles (in_valid=0) insert no write; we=0.
- CLEAR:
  - in_ready=0; input is ignored.
  - One write per cycle of the latched value, in the same (x,y) order and address mapping as LOAD.
  - After (IMG_W-1, IMG_H-1) -> DONE.
- DONE:
  - The final write (we=1) is presented this cycle and frame_done=1.
  - Unconditional -> IDLE next cycle.
- busy=1 exactly when state is LOAD or CLEAR.
- we is 0 in every cycle with no pending write. address and wr_data hold their last value when we=0.
- Address arithmetic:
  - Compute x*IMG_H+y at ADDR_W bits; no truncation occurs for legal parameters.
  - Max address with defaults: 79*80+79 = 6399.
- Simultaneous events:
  - clear and start in the same cycle: clear wins.
  - start or clear while busy: abort the current frame and restart at (0,0) in the commanded mode. A beat presented that cycle is discarded, and in_ready is forced 0 that cycle. A write already registered from the previous cycle still completes.
  - start or clear in DONE: ignored.
- in_valid outside LOAD: no effect.
- The block never reads the memory. The display side owns the read port, so there is no arbitration here.

Test Plan:
- Reset then start, stream 6400 bytes with in_valid held high -> 6400 we pulses. Byte k lands at address (k%80)*80 + k/80: byte 1 -> 80, byte 80 -> 1, byte 6399 -> 6399. frame_done pulses once, on the last write; busy returns to 0.
- Start, stream with in_valid toggling 1,0,1,0 -> we appears only the cycle after each accepted beat, and the address sequence is unchanged.
- clear with clear_value=8'h03 -> 6400 consecutive writes of 8'h03 to addresses 0,80,...,6320,1,81,...; in_ready stays 0 throughout; frame_done after 6400 writes.
- Start, 100 beats, then start again -> the next accepted beat writes address 0; no frame_done for the aborted frame.
- start and clear asserted in the same IDLE cycle -> CLEAR mode entered; in_ready=0.
- Assert rst mid-LOAD (after 50 beats) -> we, busy, in_ready and address drop to 0 without waiting for a clock edge. A subsequent start writes byte 0 to address 0.
